mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk.
REQ-002 clk  input  1  system clock.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 if_req  input  1  instruction-fetch read request; held high with stable if_addr until if_gnt.
REQ-005 if_addr  input  32  fetch word address.
REQ-006 if_gnt  output  1  one-cycle pulse: fetch request accepted.
REQ-007 if_rvalid  output  1  one-cycle pulse: if_rdata holds fetched word.
REQ-008 d_req  input  1  data request; held high with stable d_addr/d_we/d_wdata until d_gnt.
REQ-009 d_we  input  1  1 = store, 0 = load.
REQ-010 d_addr  input  32  data word address.
REQ-011 d_wdata  input  32  store data.
REQ-012 d_gnt  output  1  one-cycle pulse: data request accepted.
REQ-013 d_rvalid  output  1  one-cycle pulse: d_rdata holds loaded word (loads only).
REQ-014 if_rdata, d_rdata  output  32  registered read data.
REQ-015 mem_addr  output  32  address to synchronous memory.
REQ-016 mem_wdata  output  32  write data to memory.
REQ-017 mem_we  output  1  memory write enable.
REQ-018 mem_rdata  input  32  memory read data, valid one cycle after the address cycle.
REQ-019 busy  output  1  high in every state except IDLE.

Function
REQ-020 FSM states: IDLE, ACCESS, WAIT, RESP.
REQ-021 IDLE: if any request is high at cycle T, latch winner, address, we, wdata; next state ACCESS; else stay IDLE.
REQ-022 ACCESS (T+1): winner's gnt = 1; mem_addr/mem_wdata = latched values; mem_we = latched we; next state IDLE for a store, WAIT for a read.
REQ-023 WAIT (T+2): capture mem_rdata into the winner's rdata register at end of cycle; next state RESP.
REQ-024 RESP (T+3): winner's rvalid = 1; next state IDLE.
REQ-025 Latency: load/fetch request to rvalid = 3 cycles; store occupies 2 cycles (IDLE, ACCESS).
REQ-026 Requests are sampled only in IDLE; req levels in ACCESS/WAIT/RESP are ignored.
REQ-027 mem_we SHALL be 0 in every state except ACCESS of a store; if_gnt/d_gnt never both 1; if_rvalid/d_rvalid never both 1.
REQ-028 mem_addr/mem_wdata hold their last latched value outside ACCESS; the non-winning rdata register is unchanged.
REQ-029 Only one request high in IDLE: that requester wins regardless of priority mode.

Reset
REQ-030 Reset SHALL force state IDLE on the next edge and drop any in-flight transaction (no gnt/rvalid for it).
REQ-031 Reset values: if_gnt, d_gnt, if_rvalid, d_rvalid, mem_we, busy = 0; mem_addr, mem_wdata, if_rdata, d_rdata = 0; last-owner = data.

Configuration
REQ-032 Macro MEM_ARBITER_RR_EN SHALL select the tie-break when if_req and d_req are both high in IDLE.
REQ-033 With MEM_ARBITER_RR_EN defined: round-robin; grant the requester that did not win the previous arbitration (last-owner register, updated on each grant).
REQ-034 Without MEM_ARBITER_RR_EN: fixed priority, data port always wins; no last-owner register.

Verification
REQ-035 Fetch read: if_req=1, if_addr=0x10, mem_rdata=0xDEADBEEF in WAIT -> if_gnt at T+1, mem_addr=0x10, if_rvalid at T+3 with if_rdata=0xDEADBEEF.
REQ-036 Store: d_req=1, d_we=1, d_addr=0x40, d_wdata=0x12345678 -> T+1 d_gnt=1, mem_we=1, mem_addr=0x40, mem_wdata=0x12345678; busy=0 at T+2; no d_rvalid.
REQ-037 Contention, RR defined: both req held from reset -> grants alternate fetch, data, fetch, data; without macro -> data granted every arbitration, fetch starves while d_req high.
REQ-038 Reset in WAIT of a fetch -> next cycle IDLE, busy=0, no if_rvalid, if_rdata=0.
REQ-039 Requests raised during ACCESS/WAIT/RESP of another transaction -> not granted until the IDLE cycle following RESP (or following ACCESS for a store).
REQ-040 Assertions across all tests: at most one gnt, at most one rvalid per cycle; mem_we only in ACCESS.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single synchronous memory.
// Define MEM_ARBITER_RR_EN for round-robin tie-break; otherwise the data port has fixed priority.
module mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t      state_r, state_s;
  logic        winner_r, winner_s;   // 1 = data port owns the transaction
  logic        we_r, we_s;
  logic [31:0] addr_r, addr_s;
  logic [31:0] wdata_r, wdata_s;
  logic        data_wins_s;
  logic        if_gnt_r, d_gnt_r, if_rvalid_r, d_rvalid_r, mem_we_r, busy_r;
  logic [31:0] if_rdata_r, d_rdata_r;

`ifdef MEM_ARBITER_RR_EN
  logic last_owner_r;                // 1 = data won the previous arbitration

  // On a tie, grant the port that lost the previous arbitration.
  assign data_wins_s = d_req & (~if_req | ~last_owner_r);

  // Last-owner register, updated whenever an arbitration is decided.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner_r <= 1'b1;
    end else if ((state_r == IDLE) && (if_req || d_req)) begin
      last_owner_r <= data_wins_s;
    end
  end
`else
  assign data_wins_s = d_req;
`endif

  // Next-state and next-transaction decode.
  always_comb begin
    state_s  = state_r;
    winner_s = winner_r;
    we_s     = we_r;
    addr_s   = addr_r;
    wdata_s  = wdata_r;
    case (state_r)
      IDLE: begin
        if (if_req || d_req) begin
          state_s  = ACCESS;
          winner_s = data_wins_s;
          if (data_wins_s) begin
            addr_s  = d_addr;
            we_s    = d_we;
            wdata_s = d_wdata;
          end else begin
            addr_s  = if_addr;
            we_s    = 1'b0;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS:  state_s = we_r ? IDLE : WAIT;
      WAIT:    state_s = RESP;
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, latched transaction and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      winner_r    <= 1'b0;
      we_r        <= 1'b0;
      addr_r      <= 32'h0000_0000;
      wdata_r     <= 32'h0000_0000;
      if_gnt_r    <= 1'b0;
      d_gnt_r     <= 1'b0;
      if_rvalid_r <= 1'b0;
      d_rvalid_r  <= 1'b0;
      mem_we_r    <= 1'b0;
      busy_r      <= 1'b0;
      if_rdata_r  <= 32'h0000_0000;
      d_rdata_r   <= 32'h0000_0000;
    end else begin
      state_r     <= state_s;
      winner_r    <= winner_s;
      we_r        <= we_s;
      addr_r      <= addr_s;
      wdata_r     <= wdata_s;
      if_gnt_r    <= (state_s == ACCESS) & ~winner_s;
      d_gnt_r     <= (state_s == ACCESS) & winner_s;
      mem_we_r    <= (state_s == ACCESS) & we_s;
      if_rvalid_r <= (state_s == RESP) & ~winner_s;
      d_rvalid_r  <= (state_s == RESP) & winner_s;
      busy_r      <= (state_s != IDLE);
      // Memory data is valid during WAIT; only the owner's register is written.
      if (state_r == WAIT) begin
        if (winner_r) begin
          d_rdata_r <= mem_rdata;
        end else begin
          if_rdata_r <= mem_rdata;
        end
      end
    end
  end

  assign if_gnt    = if_gnt_r;
  assign d_gnt     = d_gnt_r;
  assign if_rvalid = if_rvalid_r;
  assign d_rvalid  = d_rvalid_r;
  assign if_rdata  = if_rdata_r;
  assign d_rdata   = d_rdata_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign mem_we    = mem_we_r;
  assign busy      = busy_r;

endmodule
